inpkt_list_parser: RTL and testbench

Single-clock front end that pulls raw bytes from the host input FIFO and parses packet framing: header, payload and trailing checksum. WORD_LIST and TEMPLATE_LIST payloads pass byte-by-byte into the word/template list stage with `inpkt_end` and `is_template_list` attached. All other packet types are consumed and discarded. Header and checksum faults raise sticky error flags and stall the parser.

---
 rtl/inpkt_list_parser.sv | 162 ++++++++++++++++
 tb/tb_inpkt_list_parser.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/inpkt_list_parser.sv
// Host input packet framing parser: checks the header, routes list payloads
// byte-by-byte to the word/template list stage, discards other types.
module inpkt_list_parser #(
  parameter int VERSION                = 2,
  parameter int PKT_TYPE_WORD_LIST     = 1,
  parameter int PKT_TYPE_TEMPLATE_LIST = 4,
  parameter int PKT_MAX_LEN            = 65536
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  src_din,
  input  logic        src_empty,
  output logic        src_rd_en,
  output logic [7:0]  dout,
  output logic        wr_en,
  input  logic        full,
  output logic        inpkt_end,
  output logic        is_template_list,
  output logic [15:0] pkt_id,
  output logic        pkt_done,
  output logic        err_version,
  output logic        err_type,
  output logic        err_len,
  output logic        err_hdr_cksum,
  output logic        err_cksum
);

  localparam logic [1:0] S_HDR     = 2'd0;
  localparam logic [1:0] S_PAYLOAD = 2'd1;
  localparam logic [1:0] S_CKSUM   = 2'd2;
  localparam logic [1:0] S_ERR     = 2'd3;

  localparam logic [7:0]  VER_B   = 8'(VERSION);
  localparam logic [7:0]  TYPE_WL = 8'(PKT_TYPE_WORD_LIST);
  localparam logic [7:0]  TYPE_TL = 8'(PKT_TYPE_TEMPLATE_LIST);
  localparam logic [23:0] MAX_LEN = 24'(PKT_MAX_LEN);

  logic [1:0]  r_state;
  logic [2:0]  r_hcnt;
  logic [7:0]  r_sum;
  logic [23:0] r_len;
  logic [7:0]  r_ver;
  logic [7:0]  r_type;
  logic [23:0] r_hlen;
  logic [15:0] r_hid;
  logic [15:0] r_pkt_id;
  logic        r_tpl;
  logic        r_discard;
  logic        r_pkt_done;
  logic        r_err_version;
  logic        r_err_type;
  logic        r_err_len;
  logic        r_err_hdr_cksum;
  logic        r_err_cksum;

  logic        w_move_pl;
  logic        w_rd;
  logic        w_wr;
  logic [7:0]  w_sum;
  logic        w_type_known;
  logic        w_err_v;
  logic        w_err_t;
  logic        w_err_l;
  logic        w_err_h;

  // Discard payloads drain regardless of the list stage's back-pressure.
  assign w_move_pl    = (r_state == S_PAYLOAD) & ~src_empty & (r_discard | ~full);
  assign w_rd         = rst_n & ((((r_state == S_HDR) | (r_state == S_CKSUM)) & ~src_empty) | w_move_pl);
  assign w_wr         = rst_n & w_move_pl & ~r_discard;
  assign w_sum        = r_sum + src_din;

  assign w_type_known = (r_type == TYPE_WL) | (r_type == TYPE_TL) |
                        (r_type == 8'd2) | (r_type == 8'd3) | (r_type == 8'd5);
  assign w_err_v      = (r_ver != VER_B);
  assign w_err_t      = ~w_type_known;
  assign w_err_l      = (r_hlen == '0) | (r_hlen > MAX_LEN);
  assign w_err_h      = (w_sum != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state         <= S_HDR;
      r_hcnt          <= '0;
      r_sum           <= '0;
      r_len           <= '0;
      r_ver           <= '0;
      r_type          <= '0;
      r_hlen          <= '0;
      r_hid           <= '0;
      r_pkt_id        <= '0;
      r_tpl           <= 1'b0;
      r_discard       <= 1'b0;
      r_pkt_done      <= 1'b0;
      r_err_version   <= 1'b0;
      r_err_type      <= 1'b0;
      r_err_len       <= 1'b0;
      r_err_hdr_cksum <= 1'b0;
      r_err_cksum     <= 1'b0;
    end else begin
      r_pkt_done <= 1'b0;
      if (w_rd) begin
        case (r_state)
          S_HDR: begin
            r_hcnt <= r_hcnt + 3'd1;
            r_sum  <= w_sum;
            case (r_hcnt)
              3'd0: r_ver         <= src_din;
              3'd1: r_type        <= src_din;
              3'd2: r_hlen[7:0]   <= src_din;
              3'd3: r_hlen[15:8]  <= src_din;
              3'd4: r_hlen[23:16] <= src_din;
              3'd5: r_hid[7:0]    <= src_din;
              3'd6: r_hid[15:8]   <= src_din;
              default: begin
                // Header byte 7: the accumulated sum restarts for the payload.
                r_sum           <= '0;
                r_len           <= r_hlen;
                r_pkt_id        <= r_hid;
                r_tpl           <= (r_type == TYPE_TL);
                r_discard       <= (r_type != TYPE_WL) & (r_type != TYPE_TL);
                r_err_version   <= r_err_version   | w_err_v;
                r_err_type      <= r_err_type      | w_err_t;
                r_err_len       <= r_err_len       | w_err_l;
                r_err_hdr_cksum <= r_err_hdr_cksum | w_err_h;
                r_state <= (w_err_v | w_err_t | w_err_l | w_err_h) ? S_ERR : S_PAYLOAD;
              end
            endcase
          end
          S_PAYLOAD: begin
            r_len <= r_len - 24'd1;
            r_sum <= w_sum;
            if (r_len == 24'd1) r_state <= S_CKSUM;
          end
          S_CKSUM: begin
            r_sum <= '0;
            if (w_sum == '0) begin
              r_pkt_done <= 1'b1;
              r_state    <= S_HDR;
            end else begin
              r_err_cksum <= 1'b1;
              r_state     <= S_ERR;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign src_rd_en        = w_rd;
  assign wr_en            = w_wr;
  assign inpkt_end        = w_wr & (r_len == 24'd1);
  assign dout             = src_din;
  assign is_template_list = r_tpl;
  assign pkt_id           = r_pkt_id;
  assign pkt_done         = r_pkt_done;
  assign err_version      = r_err_version;
  assign err_type         = r_err_type;
  assign err_len          = r_err_len;
  assign err_hdr_cksum    = r_err_hdr_cksum;
  assign err_cksum        = r_err_cksum;

endmodule

// File: tb/tb_inpkt_list_parser.sv
// Randomized bench for inpkt_list_parser against a packet-level reference model.
module tb_inpkt_list_parser;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [7:0]  src_din = '0;
  logic        src_empty = 1'b1;
  logic        src_rd_en;
  logic [7:0]  dout;
  logic        wr_en;
  logic        full = 1'b0;
  logic        inpkt_end;
  logic        is_template_list;
  logic [15:0] pkt_id;
  logic        pkt_done;
  logic        err_version, err_type, err_len, err_hdr_cksum, err_cksum;

  inpkt_list_parser #(
    .VERSION(2), .PKT_TYPE_WORD_LIST(1), .PKT_TYPE_TEMPLATE_LIST(4), .PKT_MAX_LEN(65536)
  ) dut (
    .clk(clk), .rst_n(rst_n), .src_din(src_din), .src_empty(src_empty),
    .src_rd_en(src_rd_en), .dout(dout), .wr_en(wr_en), .full(full),
    .inpkt_end(inpkt_end), .is_template_list(is_template_list), .pkt_id(pkt_id),
    .pkt_done(pkt_done), .err_version(err_version), .err_type(err_type),
    .err_len(err_len), .err_hdr_cksum(err_hdr_cksum), .err_cksum(err_cksum)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [7:0]  byte_q[$];
  logic [9:0]  exp_wr[$];
  int          exp_done, exp_left;
  logic [15:0] exp_id;
  logic [4:0]  exp_err;
  bit          dead;
  int          obs_done, wr_cnt, reads, last_cyc;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic clear_model();
    byte_q.delete();
    exp_wr.delete();
    exp_done = 0; exp_left = 0; exp_id = '0; exp_err = '0; dead = 0;
    obs_done = 0; wr_cnt = 0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; src_empty = 1'b1; full = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    clear_model();
  endtask

  // Builds one packet into the byte stream and derives what the parser must do with it.
  task automatic add_pkt(input int ver, input int typ, input int len, input int id,
                         input int hdelta, input int pdelta);
    logic [7:0] h[8];
    logic [7:0] s, b;
    h[0] = 8'(ver); h[1] = 8'(typ);
    h[2] = 8'(len); h[3] = 8'(len >> 8); h[4] = 8'(len >> 16);
    h[5] = 8'(id);  h[6] = 8'(id >> 8);
    s = '0;
    for (int i = 0; i < 7; i++) s = s + h[i];
    h[7] = 8'(0) - s + 8'(hdelta);
    for (int i = 0; i < 8; i++) byte_q.push_back(h[i]);
    if (dead) begin
      exp_left += 8;
      return;
    end
    exp_id     = 16'(id);
    exp_err[4] = (ver != 2);
    exp_err[3] = !(typ >= 1 && typ <= 5);
    exp_err[2] = (len == 0) || (len > 65536);
    exp_err[1] = (8'(hdelta) != 8'd0);
    if (exp_err[4:1] != 4'd0) begin
      dead = 1;
      for (int i = 0; i < 4; i++) byte_q.push_back(8'($urandom));
      exp_left += 4;
      return;
    end
    s = '0;
    for (int i = 0; i < len; i++) begin
      b = 8'($urandom);
      byte_q.push_back(b);
      s = s + b;
      if (typ == 1 || typ == 4) exp_wr.push_back({typ == 4, i == len - 1, b});
    end
    byte_q.push_back(8'(0) - s + 8'(pdelta));
    if (8'(pdelta) != 8'd0) begin
      exp_err[0] = 1'b1;
      dead = 1;
    end else begin
      exp_done++;
    end
  endtask

  task automatic cycle(input int fmode, input int epct, input int c);
    logic [9:0] e;
    @(negedge clk);
    src_empty = (byte_q.size() == 0) || ($urandom_range(99) < epct);
    src_din   = src_empty ? 8'($urandom) : byte_q[0];
    case (fmode)
      0: full = 1'b0;
      1: full = c[0];
      2: full = 1'b1;
      default: full = 1'($urandom_range(1));
    endcase
    #2;
    if (pkt_done) obs_done++;
    if (inpkt_end && !wr_en) check("end_wo_wr", 1, 0);
    if (wr_en) begin
      wr_cnt++;
      check("wr_full", full, 0);
      if (exp_wr.size() == 0) check("extra_wr", 1, 0);
      else begin
        e = exp_wr.pop_front();
        check("wr_data", {is_template_list, inpkt_end, dout}, e);
      end
    end
    if (src_rd_en) begin
      check("rd_empty", src_empty, 0);
      if (!src_empty && byte_q.size() > 0) begin
        void'(byte_q.pop_front());
        reads++;
      end
    end
  endtask

  task automatic run(input int fmode, input int epct, input int budget, input int max_reads);
    int c = 0;
    reads = 0;
    while (byte_q.size() > 0 && c < budget && reads < max_reads) begin
      cycle(fmode, epct, c);
      c++;
    end
    last_cyc = c;
  endtask

  task automatic tail();
    for (int i = 0; i < 3; i++) cycle(0, 100, i);
  endtask

  task automatic finish_checks();
    check("leftover", byte_q.size(), exp_left);
    check("missing_wr", exp_wr.size(), 0);
    check("done_cnt", obs_done, exp_done);
    check("pkt_id", pkt_id, exp_id);
    check("err_flags", {err_version, err_type, err_len, err_hdr_cksum, err_cksum}, exp_err);
  endtask

  initial begin
    #1 rst_n = 1'b0;
    #2;
    check("rst_rd", src_rd_en, 0);
    check("rst_wr", {wr_en, inpkt_end, pkt_done}, 0);
    check("rst_tpl_id", {is_template_list, pkt_id}, 0);
    check("rst_err", {err_version, err_type, err_len, err_hdr_cksum, err_cksum}, 0);
    src_din = 8'hA5;
    #1 check("rst_dout", dout, 8'hA5);

    // Word list "ab\0" at full rate
    do_reset();
    add_pkt(2, 1, 3, 16'h1234, 0, 0);
    byte_q[8] = 8'h61; byte_q[9] = 8'h62; byte_q[10] = 8'h00; byte_q[11] = 8'h3D;
    exp_wr.delete();
    exp_wr.push_back({1'b0, 1'b0, 8'h61});
    exp_wr.push_back({1'b0, 1'b0, 8'h62});
    exp_wr.push_back({1'b0, 1'b1, 8'h00});
    run(0, 0, 200, 1 << 30);
    check("thruput", last_cyc, 12);
    tail();
    finish_checks();

    // Template list with toggling back-pressure
    do_reset();
    add_pkt(2, 4, 5, 16'h0BAD, 0, 0);
    run(1, 0, 200, 1 << 30);
    tail();
    check("tpl_wr_cnt", wr_cnt, 5);
    finish_checks();

    // Discard type ignores full, then a word list routes normally
    do_reset();
    add_pkt(2, 3, 4, 16'h0303, 0, 0);
    run(2, 0, 200, 1 << 30);
    check("discard_cyc", last_cyc, 13);
    tail();
    check("discard_wr", wr_cnt, 0);
    add_pkt(2, 1, 7, 16'h7777, 0, 0);
    run(0, 20, 400, 1 << 30);
    tail();
    finish_checks();

    // Header faults: version, type, header checksum, lengths 0 and 65537
    do_reset();
    add_pkt(1, 1, 5, 16'h0001, 0, 0);
    add_pkt(2, 1, 5, 16'h0002, 0, 0);
    run(0, 0, 200, 1 << 30);
    tail();
    finish_checks();

    do_reset();
    add_pkt(2, 9, 5, 16'h0009, 0, 0);
    run(0, 0, 100, 1 << 30);
    tail();
    finish_checks();

    do_reset();
    add_pkt(2, 4, 5, 16'h00C5, 3, 0);
    run(0, 0, 100, 1 << 30);
    tail();
    finish_checks();

    do_reset();
    add_pkt(2, 1, 0, 16'h0100, 0, 0);
    run(0, 0, 100, 1 << 30);
    tail();
    finish_checks();

    do_reset();
    add_pkt(2, 1, 65537, 16'h0101, 0, 0);
    run(0, 0, 100, 1 << 30);
    tail();
    finish_checks();

    // Payload checksum off by one stalls after delivering the payload
    do_reset();
    add_pkt(2, 1, 6, 16'hC0DE, 0, 1);
    add_pkt(2, 1, 4, 16'hC0DF, 0, 0);
    run(0, 10, 300, 1 << 30);
    tail();
    finish_checks();

    // Asynchronous reset mid-payload, then a fresh packet
    do_reset();
    add_pkt(2, 4, 10, 16'hBEEF, 0, 0);
    run(0, 0, 100, 10);
    @(posedge clk);
    #2;
    src_empty = 1'b0; src_din = 8'h55; full = 1'b0;
    rst_n = 1'b0;
    #1;
    check("mid_wr_cnt", wr_cnt, 2);
    check("mid_rst_out", {src_rd_en, wr_en, inpkt_end, pkt_done}, 0);
    check("mid_rst_tpl_id", {is_template_list, pkt_id}, 0);
    check("mid_rst_err", {err_version, err_type, err_len, err_hdr_cksum, err_cksum}, 0);
    check("mid_rst_dout", dout, 8'h55);
    @(negedge clk);
    rst_n = 1'b1;
    src_empty = 1'b1;
    clear_model();
    add_pkt(2, 1, 1, 16'h4242, 0, 0);
    run(0, 0, 100, 1 << 30);
    tail();
    finish_checks();

    // Randomized mix of list and discard packets with random flow control
    for (int r = 0; r < 4; r++) begin
      do_reset();
      for (int k = 0; k < 6; k++) begin
        int tsel;
        tsel = $urandom_range(4);
        add_pkt(2, (tsel == 0) ? 1 : (tsel == 1) ? 4 : tsel, $urandom_range(20, 1),
                $urandom_range(65535), 0, 0);
      end
      run(3, 30, 4000, 1 << 30);
      tail();
      finish_checks();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
